// File: rtl/gray_seq_checker.sv
// Gray-code sequence checker: decodes upstream Gray samples, flags illegal steps and counts wraps.
// Optional GRAY_OVERFLOW_CHECK_EN: wraps must coincide with OverflowIn, and a fresh OverflowIn rise elsewhere is an error.
module gray_seq_checker #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Valid,
  input  logic [WIDTH-1:0]  GrayIn,
  input  logic              OverflowIn,
  input  logic              Resync,
  input  logic              ErrClear,
  output logic [WIDTH-1:0]  BinOut,
  output logic              BinValid,
  output logic              Step,
  output logic [WRAP_W-1:0] WrapCount,
  output logic              Error,
  output logic [1:0]        State
);

  typedef enum logic [1:0] {IDLE = 2'b00, TRACK = 2'b01, ERR = 2'b10} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   last_gray, gray_n, bin_n, dec;
  logic [WRAP_W-1:0]  wrap_n;
  logic               err_n, bv_n, step_n;
  logic               is_next, is_wrap, bad_ovf;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign dec     = gray2bin(GrayIn);
  assign is_next = (dec == BinOut + WIDTH'(1));
  assign is_wrap = is_next && (dec == '0);

`ifdef GRAY_OVERFLOW_CHECK_EN
  logic last_ovf, ovf_n;
  // A wrap needs the overflow flag; any other sample must not see it newly rise.
  assign bad_ovf = is_wrap ? !OverflowIn : (OverflowIn && !last_ovf);
  always_ff @(posedge Clk) begin
    if (Reset) last_ovf <= 1'b0;
    else       last_ovf <= ovf_n;
  end
`else
  logic unused_ovf;
  assign unused_ovf = OverflowIn;
  assign bad_ovf    = 1'b0;
`endif

  always_comb begin
    state_n = state;
    gray_n  = last_gray;
    bin_n   = BinOut;
    wrap_n  = WrapCount;
    err_n   = Error;
    bv_n    = 1'b0;
    step_n  = 1'b0;
`ifdef GRAY_OVERFLOW_CHECK_EN
    ovf_n   = last_ovf;
`endif
    // Control inputs take precedence and discard any concurrent sample.
    if (state == ERR && ErrClear) begin
      err_n   = 1'b0;
      state_n = IDLE;
    end else if (Resync) begin
      state_n = IDLE;
    end else if (Valid && state != ERR) begin
      bv_n   = 1'b1;
      bin_n  = dec;
      gray_n = GrayIn;
`ifdef GRAY_OVERFLOW_CHECK_EN
      ovf_n  = OverflowIn;
`endif
      if (state == IDLE) begin
        state_n = TRACK;
      end else if ((GrayIn == last_gray || is_next) && !bad_ovf) begin
        step_n = is_next;
        if (is_wrap && WrapCount != '1) wrap_n = WrapCount + WRAP_W'(1);
      end else begin
        err_n   = 1'b1;
        state_n = ERR;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      last_gray <= '0;
      BinOut    <= '0;
      BinValid  <= 1'b0;
      Step      <= 1'b0;
      WrapCount <= '0;
      Error     <= 1'b0;
    end else begin
      state     <= state_n;
      last_gray <= gray_n;
      BinOut    <= bin_n;
      BinValid  <= bv_n;
      Step      <= step_n;
      WrapCount <= wrap_n;
      Error     <= err_n;
    end
  end

  assign State = state;

endmodule

// File: tb/tb_gray_seq_checker.sv
// Scoreboarded bench for gray_seq_checker: a reference model queues expected outputs per driven cycle.
module tb_gray_seq_checker;

  logic       Clk = 1'b0;
  logic       Reset, Valid, OverflowIn, Resync, ErrClear;
  logic [2:0] GrayIn;
  logic [2:0] BinOut;
  logic       BinValid, Step, Error;
  logic [7:0] WrapCount;
  logic [1:0] State;

  gray_seq_checker #(.WIDTH(3), .WRAP_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Valid(Valid), .GrayIn(GrayIn), .OverflowIn(OverflowIn),
    .Resync(Resync), .ErrClear(ErrClear), .BinOut(BinOut), .BinValid(BinValid),
    .Step(Step), .WrapCount(WrapCount), .Error(Error), .State(State)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0] bin;
    logic       bv;
    logic       stp;
    logic [7:0] wrap;
    logic       err;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [2:0] gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  // reference model state
  logic [1:0] m_st;
  logic [2:0] m_bin, m_gray;
  logic [7:0] m_wrap;
  logic       m_err, m_ovf;

  function automatic logic [2:0] ref_dec(input logic [2:0] g);
    logic [2:0] b;
    for (int i = 0; i < 3; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic drive(input logic v, input logic [2:0] g, input logic o,
                       input logic rs, input logic ec, input logic rst);
    logic [2:0] b, inc;
    logic       bv, stp, bad, legal;
    @(negedge Clk);
    Reset = rst; Valid = v; GrayIn = g; OverflowIn = o; Resync = rs; ErrClear = ec;
    bv = 1'b0; stp = 1'b0;
    b = ref_dec(g);
    inc = m_bin + 3'd1;
    if (rst) begin
      m_st = 2'b00; m_bin = 3'd0; m_gray = 3'd0; m_wrap = 8'd0; m_err = 1'b0; m_ovf = 1'b0;
    end else begin
      case (m_st)
        2'b10: begin
          if (ec) begin m_err = 1'b0; m_st = 2'b00; end
          else if (rs) m_st = 2'b00;
        end
        default: begin
          if (rs) m_st = 2'b00;
          else if (v) begin
            legal = (g == m_gray) || (b == inc);
            bad = 1'b0;
`ifdef GRAY_OVERFLOW_CHECK_EN
            if (b == inc && b == 3'd0) bad = !o;
            else                       bad = o && !m_ovf;
`endif
            bv = 1'b1;
            if (m_st == 2'b00) m_st = 2'b01;
            else if (legal && !bad) begin
              if (b == inc) begin
                stp = 1'b1;
                if (b == 3'd0 && m_wrap != 8'hFF) m_wrap = m_wrap + 8'd1;
              end
            end else begin
              m_err = 1'b1; m_st = 2'b10;
            end
            m_bin = b; m_gray = g; m_ovf = o;
          end
        end
      endcase
    end
    sb.push_back('{bin: m_bin, bv: bv, stp: stp, wrap: m_wrap, err: m_err, st: m_st});
    @(posedge Clk);
    #2;
  endtask

  // Scoreboard: each driven cycle's expectation is compared just after the edge it takes effect on.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (BinOut !== e.bin || BinValid !== e.bv || Step !== e.stp ||
            WrapCount !== e.wrap || Error !== e.err || State !== e.st) begin
          n_bad++;
          $display("FAIL scoreboard t=%0t: got bin=%0d bv=%b step=%b wrap=%0d err=%b st=%b want bin=%0d bv=%b step=%b wrap=%0d err=%b st=%b",
                   $time, BinOut, BinValid, Step, WrapCount, Error, State,
                   e.bin, e.bv, e.stp, e.wrap, e.err, e.st);
        end
      end
    end
  end

  task automatic test_reset();
    drive(0, 3'd0, 0, 0, 0, 1);
    drive(0, 3'd0, 0, 0, 0, 1);
    n_cmp++;
    if (BinOut !== 3'd0 || BinValid !== 1'b0 || Step !== 1'b0 || WrapCount !== 8'd0 ||
        Error !== 1'b0 || State !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_state: got bin=%0d wrap=%0d err=%b st=%b, want all zero", BinOut, WrapCount, Error, State);
    end
  endtask

  task automatic test_count_wrap();
    for (int i = 0; i < 8; i++) drive(1, gseq[i], 1, 0, 0, 0);
    n_cmp++;
    if (BinOut !== 3'd7 || Step !== 1'b1 || State !== 2'b01 || Error !== 1'b0) begin
      n_bad++;
      $display("FAIL count_to_7: got bin=%0d step=%b st=%b err=%b, want 7 1 01 0", BinOut, Step, State, Error);
    end
    drive(1, 3'b000, 1, 0, 0, 0);
    n_cmp++;
    if (BinOut !== 3'd0 || Step !== 1'b1 || WrapCount !== 8'd1) begin
      n_bad++;
      $display("FAIL first_wrap: got bin=%0d step=%b wrap=%0d, want 0 1 1", BinOut, Step, WrapCount);
    end
    for (int w = 0; w < 300; w++)
      for (int i = 1; i <= 8; i++) drive(1, gseq[i % 8], 1, 0, 0, 0);
    n_cmp++;
    if (WrapCount !== 8'd255 || Error !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_saturate: got wrap=%0d err=%b, want 255 0", WrapCount, Error);
    end
  endtask

  task automatic test_error_clear();
    drive(1, 3'b001, 1, 0, 0, 0);
    drive(1, 3'b011, 1, 0, 0, 0);
    drive(1, 3'b110, 1, 0, 0, 0);
    n_cmp++;
    if (Error !== 1'b1 || State !== 2'b10 || BinOut !== 3'd4 || BinValid !== 1'b1) begin
      n_bad++;
      $display("FAIL skip_error: got err=%b st=%b bin=%0d bv=%b, want 1 10 4 1", Error, State, BinOut, BinValid);
    end
    drive(1, 3'b111, 1, 0, 0, 0);
    drive(1, 3'b000, 1, 1, 0, 0);
    n_cmp++;
    if (BinValid !== 1'b0 || State !== 2'b00 || Error !== 1'b1) begin
      n_bad++;
      $display("FAIL resync_keeps_err: got bv=%b st=%b err=%b, want 0 00 1", BinValid, State, Error);
    end
    drive(1, 3'b010, 1, 0, 0, 0);
    drive(1, 3'b000, 1, 0, 0, 0);
    drive(1, 3'b001, 1, 1, 1, 0);
    n_cmp++;
    if (Error !== 1'b0 || State !== 2'b00 || WrapCount !== 8'd255 || BinValid !== 1'b0) begin
      n_bad++;
      $display("FAIL errclear: got err=%b st=%b wrap=%0d bv=%b, want 0 00 255 0", Error, State, WrapCount, BinValid);
    end
  endtask

  task automatic test_repeat_backward();
    for (int i = 0; i < 5; i++) drive(1, 3'b010, 0, 0, 0, 0);
    n_cmp++;
    if (BinValid !== 1'b1 || Step !== 1'b0 || Error !== 1'b0 || BinOut !== 3'd3) begin
      n_bad++;
      $display("FAIL repeat_code: got bv=%b step=%b err=%b bin=%0d, want 1 0 0 3", BinValid, Step, Error, BinOut);
    end
    drive(1, 3'b011, 0, 0, 0, 0);
    n_cmp++;
    if (Error !== 1'b1 || State !== 2'b10 || BinOut !== 3'd2) begin
      n_bad++;
      $display("FAIL backward_step: got err=%b st=%b bin=%0d, want 1 10 2", Error, State, BinOut);
    end
    drive(0, 3'b000, 0, 0, 1, 0);
  endtask

  task automatic test_reset_mid();
    drive(0, 3'd0, 0, 0, 0, 1);
    drive(1, 3'b000, 1, 0, 0, 0);
    for (int w = 0; w < 3; w++)
      for (int i = 1; i <= 8; i++) drive(1, gseq[i % 8], 1, 0, 0, 0);
    drive(1, 3'b110, 1, 0, 0, 0);
    n_cmp++;
    if (WrapCount !== 8'd3 || State !== 2'b10) begin
      n_bad++;
      $display("FAIL pre_reset: got wrap=%0d st=%b, want 3 10", WrapCount, State);
    end
    drive(1, 3'b111, 1, 0, 0, 1);
    n_cmp++;
    if (BinOut !== 3'd0 || BinValid !== 1'b0 || WrapCount !== 8'd0 || Error !== 1'b0 || State !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_mid: got bin=%0d bv=%b wrap=%0d err=%b st=%b, want zeros", BinOut, BinValid, WrapCount, Error, State);
    end
    drive(1, 3'b011, 1, 1, 0, 0);
    n_cmp++;
    if (BinValid !== 1'b0 || State !== 2'b00 || BinOut !== 3'd0) begin
      n_bad++;
      $display("FAIL resync_with_valid: got bv=%b st=%b bin=%0d, want 0 00 0", BinValid, State, BinOut);
    end
  endtask

  task automatic test_overflow();
    drive(0, 3'd0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) drive(1, gseq[i], 0, 0, 0, 0);
    drive(1, 3'b000, 0, 0, 0, 0);
    n_cmp++;
`ifdef GRAY_OVERFLOW_CHECK_EN
    if (Error !== 1'b1 || State !== 2'b10 || WrapCount !== 8'd0 || Step !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_no_ovf: got err=%b st=%b wrap=%0d step=%b, want 1 10 0 0", Error, State, WrapCount, Step);
    end
`else
    if (Error !== 1'b0 || Step !== 1'b1 || WrapCount !== 8'd1) begin
      n_bad++;
      $display("FAIL wrap_ovf_ignored: got err=%b step=%b wrap=%0d, want 0 1 1", Error, Step, WrapCount);
    end
`endif
  endtask

  initial begin
    Reset = 1'b1; Valid = 1'b0; GrayIn = 3'd0; OverflowIn = 1'b0; Resync = 1'b0; ErrClear = 1'b0;
    m_st = 2'b00; m_bin = 3'd0; m_gray = 3'd0; m_wrap = 8'd0; m_err = 1'b0; m_ovf = 1'b0;
    test_reset();
    test_count_wrap();
    test_error_clear();
    test_repeat_backward();
    test_reset_mid();
    test_overflow();
    drive(0, 3'd0, 0, 0, 0, 0);
    @(negedge Clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_seq_checker.md
Name: gray_seq_checker

Overview:
- Downstream consumer of the 3-bit Gray counter stage.
- Samples the counter's Gray output and converts it back to binary.
- Checks that each new sample is either unchanged or exactly one legal +1 step. Counts wrap-arounds and latches sequence errors in a small state machine.
- Results feed the board-level status/LED logic.

Parameters:
- WIDTH, 3, Gray/binary code width; must match the upstream counter.
- WRAP_W, 8, width of the wrap counter.

Ports:
- Clk  input  1  system clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high; clears all state
- Valid  input  1  sample strobe; GrayIn/OverflowIn captured when 1
- GrayIn  input  WIDTH  Gray code from upstream counter
- OverflowIn  input  1  upstream overflow flag (sticky upstream)
- Resync  input  1  forget history, return to IDLE
- ErrClear  input  1  clear latched error, return to IDLE
- BinOut  output  WIDTH  binary decode of last accepted sample
- BinValid  output  1  1-cycle pulse, BinOut updated
- Step  output  1  1-cycle pulse, sample was a legal +1 advance
- WrapCount  output  WRAP_W  number of max->0 wraps, saturating
- Error  output  1  sticky sequence-error flag
- State  output  2  FSM state: 00 IDLE, 01 TRACK, 10 ERR

Behaviour:
- Clock and reset: single clock Clk; reset Reset is synchronous and active-high. Reset has priority over every other input.
- Reset values: BinOut=0, BinValid=0, Step=0, WrapCount=0, Error=0, State=IDLE, internal last_gray=0, last_bin=0.
- Gray decode: bin[WIDTH-1]=g[WIDTH-1]; bin[i]=bin[i+1]^g[i] for i down to 0.
- Latency: all outputs are registered and reflect a sample one cycle after the Valid edge. BinValid and Step are single-cycle pulses, 0 otherwise.
- Legal step: dec(GrayIn) == last_bin+1 mod 2^WIDTH. This also implies a Hamming distance of 1 to last_gray.
- IDLE:
  - Valid=1: capture GrayIn as last_gray, BinOut=dec(GrayIn), BinValid=1.
  - Step=0, no check performed.
  - Next state TRACK.
- TRACK, Valid=1, same code (GrayIn==last_gray): BinValid=1, Step=0, state unchanged.
- TRACK, Valid=1, legal step: update last_gray/BinOut, BinValid=1, Step=1.
  - If last_bin==2^WIDTH-1 (new bin 0), WrapCount increments.
  - WrapCount saturates at all-ones; no roll-over.
- TRACK, Valid=1, anything else (multi-bit change, backward step, skip):
  - Error=1, State=ERR, BinOut still updated to the decoded value, BinValid=1, Step=0.
- ERR:
  - Samples are ignored: no BinValid, no Step, no updates.
  - ErrClear=1: Error=0, State=IDLE; WrapCount is retained.
- Resync=1 in any state: State=IDLE, Step=0; Error and WrapCount unchanged. Resync does not clear an error; only ErrClear or Reset does.
- Simultaneous events:
  - Resync or ErrClear in the same cycle as Valid: the control input wins and the sample is discarded.
  - ErrClear and Resync together in ERR: go to IDLE with Error=0.
  - ErrClear outside ERR: no effect.
- Valid=0: no state change, pulses 0.
- Reset mid-operation: all state returns to reset values on the next edge regardless of FSM state.
- Upstream counter reset causes a jump to code 0, which is flagged as an error unless Resync is pulsed alongside it.

Optional Feature:
- Macro: GRAY_OVERFLOW_CHECK_EN.
- Defined: a wrap (max->0 legal step) is accepted only if OverflowIn==1 in the same sample.
  - Wrap with OverflowIn=0: Error, state ERR, WrapCount not incremented.
  - Any non-wrap sample with OverflowIn rising 0->1 relative to the previous accepted sample: Error, state ERR.
  - Requires one extra register, last_ovf, reset to 0.
- Undefined: OverflowIn is ignored entirely; wraps are judged on code values only.

Test Plan:
- Reset, then Valid each cycle with Gray 000,001,011,010,110,111,101,100 -> BinOut 0..7 one cycle later, Step=1 from second sample on, Error=0, State=01.
- Continue with 000 (OverflowIn=1) -> BinOut=0, Step=1, WrapCount=1. Run 300 further wraps -> WrapCount saturates at 255.
- In TRACK at gray 011 (bin 2), present 110 (bin 4) -> Error=1, State=10, BinOut=4. Further Valid samples -> no BinValid. ErrClear -> Error=0, State=00, WrapCount unchanged.
- Repeat the same code 010 for 5 Valid cycles -> BinValid pulses each sample, Step=0, no error. Backward step 010->011 (bin 3->2) -> Error.
- Assert Reset while in ERR with WrapCount=3 -> next cycle all outputs 0, State=00. Resync+Valid in the same cycle -> sample ignored, State=00.
- With GRAY_OVERFLOW_CHECK_EN defined: wrap 100->000 with OverflowIn=0 -> Error=1, WrapCount unchanged. Without the macro, same stimulus -> Step=1, WrapCount+1.
